i2c_codec_reg_responder: RTL and testbench

I2C target (responder) that emulates the WM8731 codec's write-only control port. It decodes 3-byte write transactions (device address, register address plus data MSB, data LSBs) and ACKs them by pulling SDA low. It holds a 16 x 9-bit register file with codec power-on defaults and emits a one-cycle write strobe per accepted word. It sits opposite the codec configuration master: in simulation as a codec model, and on-chip as an FPGA-side configuration target.

---
 rtl/i2c_codec_pkg.sv | 43 ++++
 rtl/i2c_codec_reg_responder_i2c_bus_sync.sv | 69 ++++++
 rtl/i2c_codec_reg_responder.sv | 193 +++++++++++++++++++
 tb/tb_i2c_codec_reg_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the WM8731-style I2C control-port responder:
// target address default, register indices, power-on defaults and FSM states.
package i2c_codec_pkg;

    localparam logic [6:0] DEVICE_ADDR_DEFAULT = 7'b0011010;
    localparam int unsigned NUM_REGS = 16;

    // Codec register indices
    localparam logic [3:0] R_LLIN   = 4'd0;
    localparam logic [3:0] R_RLIN   = 4'd1;
    localparam logic [3:0] R_LHP    = 4'd2;
    localparam logic [3:0] R_RHP    = 4'd3;
    localparam logic [3:0] R_AAPC   = 4'd4;
    localparam logic [3:0] R_DAPC   = 4'd5;
    localparam logic [3:0] R_PDC    = 4'd6;
    localparam logic [3:0] R_DAIF   = 4'd7;
    localparam logic [3:0] R_SRC    = 4'd8;
    localparam logic [3:0] R_ACTIVE = 4'd9;
    localparam logic [3:0] R_RESET  = 4'd15;

    // Codec power-on values; R10..R15 are not backed by real registers
    localparam logic [8:0] REG_DEFAULTS [0:15] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_REG    = 3'd3,
        ST_ACK_R  = 3'd4,
        ST_DATA   = 3'd5,
        ST_ACK_D  = 3'd6,
        ST_IGNORE = 3'd7
    } i2c_state_t;

    // Addresses that map to something real: storable registers or the reset register
    function automatic logic reg_addr_valid(input logic [6:0] addr);
        return (addr <= 7'd9) || (addr == 7'd15);
    endfunction

endpackage

// File: rtl/i2c_codec_reg_responder_i2c_bus_sync.sv
// Bus front end: synchronizes SCL/SDA into clk and emits registered
// single-cycle flags for SCL rise/fall, START and STOP.
// Event latency from a pin edge is SYNC_STAGES + 1 clk cycles (minimum depth 2).
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Synchronizer chains plus one delayed copy for edge detection; idle bus reads high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    // Registered event flags; START/STOP are SDA edges with SCL high on both samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_rise <= w_scl & ~r_scl_prev;
            r_scl_fall <= ~w_scl & r_scl_prev;
            r_start    <= w_scl & r_scl_prev & r_sda_prev & ~w_sda;
            r_stop     <= w_scl & r_scl_prev & ~r_sda_prev & w_sda;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    // SDA value aligned with the flag cycle (stable while SCL is high)
    assign o_sda      = r_sda_prev;

endmodule

// File: rtl/i2c_codec_reg_responder.sv
// WM8731 control-port emulator: write-only I2C target decoding 3-byte writes
// into a 16 x 9-bit register file with codec power-on defaults.
// Optional build macro I2C_RESP_STRICT_EN: NACK register bytes whose address
// is not 0..9 or 15, so those writes are neither strobed nor stored.
// Handshake: wr_valid is a one-cycle pulse with wr_addr/wr_data valid in the
// same cycle; there is no back-pressure, the consumer must take it then.
module i2c_codec_reg_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEVICE_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       active,
    output i2c_state_t dbg_state
);

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_sda_in;
    logic       w_byte_end;
    logic       w_commit;
    logic [6:0] w_commit_addr;
    logic [8:0] w_commit_data;
    logic       w_reg_ok;

    i2c_state_t r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_reg_byte;
    logic       r_sda_oe;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic [8:0] r_rd_data;
    logic [8:0] r_regs [0:NUM_REGS-1];

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda_in)
    );

    // Open-drain: only ever pull low
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    // The SCL fall after the 8th data bit closes a byte
    assign w_byte_end    = w_scl_fall && (r_bit_cnt == 4'd8) && !w_start && !w_stop;
    assign w_commit      = (r_state == ST_DATA) && w_byte_end;
    assign w_commit_addr = r_reg_byte[7:1];
    assign w_commit_data = {r_reg_byte[0], r_shift};

`ifdef I2C_RESP_STRICT_EN
    assign w_reg_ok = reg_addr_valid(r_shift[7:1]);
`else
    assign w_reg_ok = 1'b1;
`endif

    // Protocol FSM with registered ACK drive and write strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_reg_byte <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_REG, ST_DATA: begin
                        if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                            r_shift   <= {r_shift[6:0], w_sda_in};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_end) begin
                            r_bit_cnt <= 4'd0;
                            case (r_state)
                                ST_ADDR: begin
                                    if ((r_shift[7:1] == DEVICE_ADDR) && !r_shift[0]) begin
                                        r_state  <= ST_ACK_A;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                    end
                                end
                                ST_REG: begin
                                    r_reg_byte <= r_shift;
                                    if (w_reg_ok) begin
                                        r_state  <= ST_ACK_R;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                    end
                                end
                                default: begin
                                    r_state    <= ST_ACK_D;
                                    r_sda_oe   <= 1'b1;
                                    r_wr_valid <= 1'b1;
                                    r_wr_addr  <= w_commit_addr;
                                    r_wr_data  <= w_commit_data;
                                end
                            endcase
                        end
                    end
                    ST_ACK_A: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_REG;
                        end
                    end
                    ST_ACK_R: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_DATA;
                        end
                    end
                    ST_ACK_D: begin
                        // Anything after the third byte is NACKed by silence
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_IGNORE;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    // Register file: store R0..R9, R15 restores defaults, other addresses dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= REG_DEFAULTS[i];
            end
        end else if (w_commit) begin
            if (w_commit_addr <= 7'd9) begin
                r_regs[w_commit_addr[3:0]] <= w_commit_data;
            end else if (w_commit_addr == {3'd0, R_RESET}) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_regs[i] <= REG_DEFAULTS[i];
                end
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= 9'd0;
        end else begin
            r_rd_data <= r_regs[rd_addr];
        end
    end

    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_data   = r_rd_data;
    assign active    = r_regs[R_ACTIVE][0];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_codec_reg_responder.sv
// Bench for i2c_codec_reg_responder: bit-banged I2C master, behavioural
// register model, write-strobe scoreboard and directed plus random transactions.
module tb_i2c_codec_reg_responder;

  localparam int H = 12;  // clk cycles per SCL phase
  localparam int Q = 4;   // hold after SCL fall before SDA changes
  localparam logic [8:0] TB_DEFAULTS [0:15] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
  };

  logic       clk;
  logic       reset_n;
  logic       m_scl;
  logic       m_sda_oe;
  wire        sda;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       active;
  i2c_codec_pkg::i2c_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int dut_drive_cnt = 0;
  logic prev_wv = 1'b0;
  logic [8:0] ref_regs [0:15];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_codec_reg_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (m_scl),
    .sda       (sda),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .active    (active),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe monitor: capture writes, check pulse width and ACK alignment
  always @(negedge clk) begin
    if (!m_sda_oe && sda === 1'b0) dut_drive_cnt++;
    if (prev_wv) check("wr_valid_width", {31'd0, wr_valid}, 32'd0);
    if (wr_valid === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      check("ack_with_strobe", {31'd0, sda}, 32'd0);
    end
    prev_wv = (wr_valid === 1'b1);
  end

  // reference model
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) ref_regs[i] = TB_DEFAULTS[i];
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
    if (a <= 7'd9) ref_regs[a[3:0]] = d;
    else if (a == 7'd15) model_reset();
  endfunction

  function automatic logic model_reg_ok(input logic [6:0] a);
`ifdef I2C_RESP_STRICT_EN
    return (a <= 7'd9) || (a == 7'd15);
`else
    return (a == a);
`endif
  endfunction

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; wait_clks(H);
    m_scl = 1'b1;    wait_clks(H);
    m_sda_oe = 1'b1; wait_clks(H);
    m_scl = 1'b0;    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; wait_clks(H);
    m_scl = 1'b1;    wait_clks(H);
    m_sda_oe = 1'b0; wait_clks(H);
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; wait_clks(H);
    m_scl = 1'b1;  wait_clks(H);
    m_scl = 1'b0;  wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_oe = 1'b0; wait_clks(H);
    m_scl = 1'b1;    wait_clks(H / 2);
    ack = (sda === 1'b0);
    wait_clks(H / 2);
    m_scl = 1'b0;    wait_clks(Q);
  endtask

  // scoreboard drain: every expected strobe observed, nothing extra
  task automatic drain(input string tag);
    logic [15:0] e;
    logic [15:0] o;
    wait_clks(8);
    check({tag, "_strobe_cnt"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_strobe"}, {16'd0, o}, {16'd0, e});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // full transaction: START, n bytes, optional STOP; ACKs checked against model
  task automatic xfer(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input int n, input bit do_stop);
    logic [7:0] bytes [0:3];
    logic ack;
    logic exp_ack;
    logic ok;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    i2c_start();
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], ack);
      case (i)
        0: exp_ack = (b0 == 8'h34);
        1: exp_ack = ok && model_reg_ok(b1[7:1]);
        2: exp_ack = ok;
        default: exp_ack = 1'b0;
      endcase
      ok = exp_ack;
      if (i == 2 && exp_ack) model_write(b1[7:1], {b1[0], b2});
      check($sformatf("%s_ack%0d", tag, i), {31'd0, ack}, {31'd0, exp_ack});
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      wait_clks(2);
      @(negedge clk);
      check($sformatf("%s_r%0d", tag, i), {23'd0, rd_data}, {23'd0, ref_regs[i]});
    end
    check({tag, "_active"}, {31'd0, active}, {31'd0, ref_regs[9][0]});
  endtask

  initial begin
    int drv0;
    logic ack;
    logic [7:0] rb0;
    logic [7:0] rb1;
    logic [7:0] rb2;
    reset_n = 1'b0; m_scl = 1'b1; m_sda_oe = 1'b0; rd_addr = 4'd0;
    model_reset();

    // reset state
    wait_clks(5);
    @(negedge clk);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {23'd0, wr_data}, 32'd0);
    check("rst_rd_data", {23'd0, rd_data}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, i2c_codec_pkg::ST_IDLE});
    check("rst_sda", {31'd0, sda}, 32'd1);
    reset_n = 1'b1;
    wait_clks(4);
    check_regs("defaults");

    // basic write R7 = 0x00A
    xfer("w_r7", 8'h34, 8'h0E, 8'h0A, 8'h00, 3, 1'b1);
    drain("w_r7");
    rd_addr = 4'd7; wait_clks(2); @(negedge clk);
    check("rd_r7", {23'd0, rd_data}, 32'h00A);

    // active on, then reset register
    xfer("act_on", 8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1);
    drain("act_on");
    check("active_on", {31'd0, active}, 32'd1);
    xfer("w_r4", 8'h34, 8'h08, 8'h55, 8'h00, 3, 1'b1);
    drain("w_r4");
    xfer("reset_reg", 8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1);
    drain("reset_reg");
    check("active_off", {31'd0, active}, 32'd0);
    check_regs("after_r15");

    // wrong address and read request: never driven
    drv0 = dut_drive_cnt;
    xfer("bad_addr", 8'h36, 8'h0E, 8'h33, 8'h00, 3, 1'b1);
    xfer("read_req", 8'h35, 8'h0E, 8'h33, 8'h00, 3, 1'b1);
    drain("no_target");
    check("no_drive", dut_drive_cnt, drv0);

    // partial transaction commits nothing
    xfer("partial", 8'h34, 8'h0E, 8'h00, 8'h00, 2, 1'b1);
    drain("partial");
    rd_addr = 4'd7; wait_clks(2); @(negedge clk);
    check("partial_r7", {23'd0, rd_data}, 32'h00A);

    // R0 = 0x117, repeated START mid data byte, then full write with 4th byte
    xfer("w_r0", 8'h34, 8'h01, 8'h17, 8'h00, 3, 1'b1);
    i2c_start();
    send_byte(8'h34, ack); check("rs_ack0", {31'd0, ack}, 32'd1);
    send_byte(8'h02, ack); check("rs_ack1", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    xfer("rs_full", 8'h34, 8'h04, 8'h5A, 8'hFF, 4, 1'b1);
    drain("rs");
    check_regs("after_rs");

    // address 10: strobe without store (NACK in strict build)
    xfer("addr10", 8'h34, 8'h14, 8'h33, 8'h00, 3, 1'b1);
    drain("addr10");
    check_regs("after_a10");

    // reset mid DATA byte
    i2c_start();
    send_byte(8'h34, ack); check("mr_ack0", {31'd0, ack}, 32'd1);
    send_byte(8'h0E, ack); check("mr_ack1", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    m_sda_oe = 1'b0;
    reset_n = 1'b0;
    model_reset();
    wait_clks(3);
    @(negedge clk);
    check("mr_state", {29'd0, dbg_state}, {29'd0, i2c_codec_pkg::ST_IDLE});
    check("mr_sda", {31'd0, sda}, 32'd1);
    reset_n = 1'b1;
    i2c_stop();
    xfer("mr_next", 8'h34, 8'h0C, 8'h62, 8'h00, 3, 1'b1);
    drain("mr");
    check_regs("after_mr");

    // randomized transactions against the model
    for (int t = 0; t < 14; t++) begin
      rb0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h34;
      rb1 = 8'($urandom_range(0, 31));
      rb2 = 8'($urandom_range(0, 255));
      xfer($sformatf("rnd%0d", t), rb0, rb1, rb2, 8'($urandom_range(0, 255)),
           $urandom_range(1, 4), 1'b1);
      drain($sformatf("rnd%0d", t));
    end
    check_regs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
